// File: rtl/bus_rx_pkg.sv
// Shared types and default sizing for the nibble bus receiver and its output FIFO.
// Latency: n/a (declarations only); backpressure: n/a.
package bus_rx_pkg;

  localparam int DEF_NIB_W   = 4;
  localparam int DEF_BEATS   = 4;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_GAP_MAX = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } rx_state_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_rx_fifo.sv
// Word FIFO with registered storage; head visible 1 cycle after push, zero when empty.
// Backpressure: push ignored when full unless a pop happens the same cycle.
module bus_rx_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]               wr_ptr_q, wr_ptr_d;
  logic [AW:0]               rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
  logic                      do_push, do_pop;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/bus_nibble_receiver.sv
// Samples nibbles off a shared bus into words and queues them; m_valid 1 cycle after last beat.
// Backpressure: m_ready pops the FIFO; completed words arriving while full are dropped and flagged.
module bus_nibble_receiver
  import bus_rx_pkg::*;
#(
  parameter int NIB_W   = DEF_NIB_W,
  parameter int BEATS   = DEF_BEATS,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int GAP_MAX = DEF_GAP_MAX
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NIB_W-1:0]       bus_in,
  input  logic                   bus_en_n,
  output logic [NIB_W*BEATS-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   overflow,
  output logic                   gap_err,
  input  logic                   clr_err
);

  localparam int              BW        = cnt_w(BEATS);
  localparam int              GW        = cnt_w(GAP_MAX + 1);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);
  localparam logic [GW-1:0]   GAP_LIMIT = GW'(GAP_MAX);

  rx_state_t                   state_q, state_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic [GW-1:0]               gap_q, gap_d, gap_inc;
  logic [BEATS-1:0][NIB_W-1:0] word_q, word_d;
  logic                        overflow_q, overflow_d;
  logic                        gap_err_q, gap_err_d;

  logic                        beat_vld;
  logic                        word_done;
  logic                        gap_abort;
  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                        drop_evt;
  logic [NIB_W*BEATS-1:0]      fifo_head;

  assign beat_vld = ~bus_en_n;
  assign gap_inc  = gap_q + GW'(1);

  // Assembler: the completing nibble is merged combinationally so the push lands on its own edge.
  always_comb begin
    beat_d    = beat_q;
    gap_d     = gap_q;
    word_d    = word_q;
    word_done = 1'b0;
    gap_abort = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (beat_vld) begin
          word_d    = '0;
          word_d[0] = bus_in;
          gap_d     = '0;
          if (BEATS == 1) begin
            word_done = 1'b1;
          end else begin
            beat_d = BW'(1);
          end
        end
      end
      ST_COLLECT: begin
        if (beat_vld) begin
          word_d[beat_q] = bus_in;
          gap_d          = '0;
          if (beat_q == LAST_BEAT) begin
            word_done = 1'b1;
            beat_d    = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else if (gap_inc == GAP_LIMIT) begin
          gap_abort = 1'b1;
          gap_d     = '0;
          beat_d    = '0;
        end else begin
          gap_d = gap_inc;
        end
      end
      default: begin
        beat_d = '0;
        gap_d  = '0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (beat_vld && !word_done) state_d = ST_COLLECT;
      ST_COLLECT: if (word_done || gap_abort) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A pop frees the slot in the same edge, so a full FIFO still takes a word on a handshake.
  always_comb begin
    fifo_pop   = m_valid & m_ready;
    fifo_push  = word_done & (~fifo_full | fifo_pop);
    drop_evt   = word_done & fifo_full & ~fifo_pop;
    overflow_d = overflow_q;
    gap_err_d  = gap_err_q;
    if (clr_err) begin
      overflow_d = 1'b0;
      gap_err_d  = 1'b0;
    end
    if (drop_evt) begin
      overflow_d = 1'b1;
    end
    if (gap_abort) begin
      gap_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      gap_q      <= '0;
      word_q     <= '0;
      overflow_q <= 1'b0;
      gap_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
      word_q     <= word_d;
      overflow_q <= overflow_d;
      gap_err_q  <= gap_err_d;
    end
  end

  bus_rx_fifo #(
    .W     (NIB_W * BEATS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (word_d),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (fifo_head)
  );

  assign m_valid  = ~fifo_empty;
  assign m_data   = fifo_head;
  assign overflow = overflow_q;
  assign gap_err  = gap_err_q;

endmodule

// File: tb/tb_bus_nibble_receiver.sv
// Directed bench for bus_nibble_receiver; words expected at the output are queued and checked by a monitor.
module tb_bus_nibble_receiver;

  logic        clk;
  logic        rst_n;
  logic [3:0]  bus_in;
  logic        bus_en_n;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        overflow;
  logic        gap_err;
  logic        clr_err;

  int          checks;
  int          failures;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bus_nibble_receiver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_in   (bus_in),
    .bus_en_n (bus_en_n),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .overflow (overflow),
    .gap_err  (gap_err),
    .clr_err  (clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [3:0] n);
    bus_in   = n;
    bus_en_n = 1'b0;
    tick();
    bus_en_n = 1'b1;
  endtask

  // Sends four nibbles LSB first on consecutive cycles.
  task automatic send_word(input logic [15:0] w, input bit expect_push,
                           input bit rdy_last, input bit chk_lat);
    for (int i = 0; i < 4; i++) begin
      bus_in   = w[i*4 +: 4];
      bus_en_n = 1'b0;
      if (i == 3) begin
        if (rdy_last) m_ready = 1'b1;
        if (chk_lat) check("valid_before_last_beat", {31'd0, m_valid}, 32'd0);
        if (expect_push) exp_q.push_back(w);
      end
      tick();
    end
    bus_en_n = 1'b1;
    if (rdy_last) m_ready = 1'b0;
    if (chk_lat) check("valid_one_cycle_after_last_beat", {31'd0, m_valid}, 32'd1);
  endtask

  // Monitor: every handshake must match the oldest queued word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", m_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("word_out", {16'd0, m_data}, {16'd0, mon_exp});
        end
      end
    end
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus_in   = 4'h0;
    bus_en_n = 1'b1;
    m_ready  = 1'b0;
    clr_err  = 1'b0;
    #2;
    check("reset_m_valid", {31'd0, m_valid}, 32'd0);
    check("reset_m_data", {16'd0, m_data}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_gap_err", {31'd0, gap_err}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single word with latency check, then back-to-back words.
    m_ready = 1'b1;
    send_word(16'h1234, 1'b1, 1'b0, 1'b1);
    send_word(16'hCAFE, 1'b1, 1'b0, 1'b0);
    send_word(16'hBEEF, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    check("no_overflow_streaming", {31'd0, overflow}, 32'd0);
    check("no_gap_err_streaming", {31'd0, gap_err}, 32'd0);

    // Fill with consumer stalled; fifth word is dropped.
    m_ready = 1'b0;
    send_word(16'h1111, 1'b1, 1'b0, 1'b0);
    send_word(16'h2222, 1'b1, 1'b0, 1'b0);
    send_word(16'h3333, 1'b1, 1'b0, 1'b0);
    send_word(16'h4444, 1'b1, 1'b0, 1'b0);
    send_word(16'h5555, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    check("overflow_set", {31'd0, overflow}, 32'd1);
    check("full_valid", {31'd0, m_valid}, 32'd1);
    check("head_stalled", {16'd0, m_data}, 32'h1111);
    repeat (3) tick();
    check("head_stable", {16'd0, m_data}, 32'h1111);
    m_ready = 1'b1;
    repeat (5) tick();
    m_ready = 1'b0;
    check("drained_valid", {31'd0, m_valid}, 32'd0);
    check("drained_queue", exp_q.size(), 32'd0);

    // Gap timeout discards the partial word.
    m_ready = 1'b1;
    drive_beat(4'hA);
    drive_beat(4'hB);
    repeat (7) tick();
    check("gap_err_before_limit", {31'd0, gap_err}, 32'd0);
    tick();
    check("gap_err_at_limit", {31'd0, gap_err}, 32'd1);
    check("gap_no_push", {31'd0, m_valid}, 32'd0);
    send_word(16'h4321, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();

    // Clearing both flags.
    check("overflow_still_set", {31'd0, overflow}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_overflow", {31'd0, overflow}, 32'd0);
    check("clr_gap_err", {31'd0, gap_err}, 32'd0);

    // Clear coinciding with a new gap timeout: set wins.
    drive_beat(4'hA);
    drive_beat(4'hB);
    repeat (7) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_vs_set_gap_err", {31'd0, gap_err}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_gap_err_again", {31'd0, gap_err}, 32'd0);

    // Full FIFO, last beat coincides with a pop.
    m_ready = 1'b0;
    send_word(16'hA001, 1'b1, 1'b0, 1'b0);
    send_word(16'hA002, 1'b1, 1'b0, 1'b0);
    send_word(16'hA003, 1'b1, 1'b0, 1'b0);
    send_word(16'hA004, 1'b1, 1'b0, 1'b0);
    send_word(16'hB005, 1'b1, 1'b1, 1'b0);
    check("push_pop_full_no_overflow", {31'd0, overflow}, 32'd0);
    check("head_after_pop", {16'd0, m_data}, 32'hA002);
    m_ready = 1'b1;
    repeat (6) tick();
    m_ready = 1'b0;
    check("full_pushpop_queue", exp_q.size(), 32'd0);

    // Asynchronous reset mid-word.
    send_word(16'h0F0F, 1'b0, 1'b0, 1'b0);
    tick();
    check("pre_reset_valid", {31'd0, m_valid}, 32'd1);
    bus_in   = 4'h1;
    bus_en_n = 1'b0;
    tick();
    bus_in   = 4'h2;
    tick();
    bus_en_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_m_valid", {31'd0, m_valid}, 32'd0);
    check("async_reset_m_data", {16'd0, m_data}, 32'd0);
    check("async_reset_overflow", {31'd0, overflow}, 32'd0);
    check("async_reset_gap_err", {31'd0, gap_err}, 32'd0);
    repeat (2) tick();
    #2;
    rst_n = 1'b1;
    tick();
    m_ready = 1'b1;
    send_word(16'h5678, 1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
